quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 153 +++++++++++++++
 tb/tb_quad_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync, FILT_LEN glitch filter, decode FSM; step/err outputs land FILT_LEN+3 clocks after the input edge.
// Define QDEC_ERR_CNT_EN to build the saturating illegal-transition counter on err_cnt; otherwise err_cnt is tied to zero.
module quad_decoder #(
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       dec_en,
  output logic       enable,
  output logic       up_down,
  output logic       err,
  output logic [3:0] err_cnt
);

  typedef enum logic [2:0] {INIT, S00, S01, S11, S10} state_t;

  localparam logic [3:0] FILT_W = 4'(FILT_LEN);

  logic [1:0] r_sync1, r_sync2, r_hold, r_filt;
  logic       r_filt_vld;
  logic [3:0] r_cnt;
  logic [3:0] w_run;
  logic       w_match;
  state_t     r_state, w_next, w_tgt;
  logic       w_fwd, w_rev, w_bad;
  logic       r_fwd, r_rev, r_bad;
  logic       r_enable, r_up_down, r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {a_in, b_in};
      r_sync2 <= r_sync1;
    end
  end

  // Before the first acceptance nothing counts as "matching", so a stable level after reset is taken as the start state.
  always_comb begin
    w_match = r_filt_vld && (r_sync2 == r_filt);
    w_run   = ((r_cnt == 4'd0) || (r_sync2 != r_hold)) ? 4'd1 : r_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= 4'd0;
      r_hold     <= 2'b00;
      r_filt     <= 2'b00;
      r_filt_vld <= 1'b0;
    end else if (w_match) begin
      r_cnt <= 4'd0;
    end else if (w_run == FILT_W) begin
      r_filt     <= r_sync2;
      r_filt_vld <= 1'b1;
      r_cnt      <= 4'd0;
    end else begin
      r_cnt  <= w_run;
      r_hold <= r_sync2;
    end
  end

  always_comb begin
    case (r_filt)
      2'b00:   w_tgt = S00;
      2'b01:   w_tgt = S01;
      2'b11:   w_tgt = S11;
      default: w_tgt = S10;
    endcase
    w_next = r_state;
    w_fwd  = 1'b0;
    w_rev  = 1'b0;
    w_bad  = 1'b0;
    if (r_filt_vld && (w_tgt != r_state)) begin
      w_next = w_tgt;
      case (r_state)
        S00: begin
          w_fwd = (w_tgt == S01);
          w_rev = (w_tgt == S10);
          w_bad = (w_tgt == S11);
        end
        S01: begin
          w_fwd = (w_tgt == S11);
          w_rev = (w_tgt == S00);
          w_bad = (w_tgt == S10);
        end
        S11: begin
          w_fwd = (w_tgt == S10);
          w_rev = (w_tgt == S01);
          w_bad = (w_tgt == S00);
        end
        S10: begin
          w_fwd = (w_tgt == S00);
          w_rev = (w_tgt == S11);
          w_bad = (w_tgt == S01);
        end
        default: begin
          w_fwd = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= INIT;
      r_fwd   <= 1'b0;
      r_rev   <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fwd   <= w_fwd;
      r_rev   <= w_rev;
      r_bad   <= w_bad;
    end
  end

  // dec_en gates only the output stage; the filter and FSM keep following the encoder.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable  <= 1'b0;
      r_err     <= 1'b0;
      r_up_down <= 1'b1;
    end else begin
      r_enable <= dec_en && (r_fwd || r_rev);
      r_err    <= dec_en && r_bad;
      if (dec_en && (r_fwd || r_rev)) r_up_down <= r_fwd;
    end
  end

  assign enable  = r_enable;
  assign err     = r_err;
  assign up_down = r_up_down;

`ifdef QDEC_ERR_CNT_EN
  logic [3:0] r_err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= 4'h0;
    end else if (dec_en && r_bad && (r_err_cnt != 4'hF)) begin
      r_err_cnt <= r_err_cnt + 4'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 4'h0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenario tasks plus a randomized run against a window-based reference model.
module tb_quad_decoder;

  localparam int F = 3;
`ifdef QDEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       a_in, b_in, dec_en;
  logic       enable, up_down, err;
  logic [3:0] err_cnt;

  quad_decoder #(.FILT_LEN(F)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .dec_en(dec_en),
    .enable(enable), .up_down(up_down), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_chg    = 0;
  int n_en, n_up, n_dn, n_err, n_both, n_lat_ok;
  logic [15:0] dirs;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a level is accepted once the last F synchronized samples agree and differ from the
  // accepted level; its quadrature position delta (1 fwd, 3 rev, 2 illegal) appears on the outputs two clocks later.
  logic [1:0] m_d1, m_d2, m_seen;
  logic [1:0] m_win[$];
  logic [1:0] m_filt;
  bit         m_vld, m_same;
  int         m_pos, m_ev1, m_ev2, m_ev;
  bit         exp_en, exp_err, exp_ud;
  logic [3:0] exp_cnt;

  function automatic int pos_of(logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_d1 = 2'b00; m_d2 = 2'b00; m_win.delete();
      m_pos = -1; m_vld = 0; m_filt = 2'b00; m_ev1 = 0; m_ev2 = 0;
      exp_en = 0; exp_err = 0; exp_ud = 1; exp_cnt = 4'h0;
    end else begin
      exp_en  = dec_en && (m_ev2 == 1 || m_ev2 == 3);
      exp_err = dec_en && (m_ev2 == 2);
      if (exp_en) exp_ud = (m_ev2 == 1);
      if (CNT_EN && exp_err && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      m_ev2  = m_ev1;
      m_seen = m_d2;
      m_d2   = m_d1;
      m_d1   = {a_in, b_in};
      m_win.push_back(m_seen);
      if (m_win.size() > F) void'(m_win.pop_front());
      m_ev = 0;
      if (m_win.size() == F) begin
        m_same = 1;
        foreach (m_win[i]) if (m_win[i] != m_seen) m_same = 0;
        if (m_same && (!m_vld || m_seen != m_filt)) begin
          m_vld  = 1;
          m_filt = m_seen;
          if (m_pos >= 0) m_ev = (pos_of(m_seen) - m_pos + 4) % 4;
          m_pos = pos_of(m_seen);
        end
      end
      m_ev1 = m_ev;
    end
  end

  task automatic clear_tally();
    n_en = 0; n_up = 0; n_dn = 0; n_err = 0; n_both = 0; n_lat_ok = 0; dirs = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (enable) begin
      n_en++;
      if (up_down) n_up++; else n_dn++;
      dirs = {dirs[14:0], up_down};
      if (cyc - t_chg == F + 3) n_lat_ok++;
    end
    if (err) n_err++;
    if (enable && err) n_both++;
  endtask

  task automatic set_ab(input logic [1:0] ab, input int hold);
    {a_in, b_in} = ab;
    t_chg = cyc + 1;
    repeat (hold) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; a_in = 1'b0; b_in = 1'b0; dec_en = 1'b1;
    clear_tally();
    repeat (3) @(negedge clk);
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got=%b exp=0", enable); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_checks++; if (up_down !== 1'b1) begin n_fail++; $display("FAIL reset_up_down got=%b exp=1", up_down); end
    n_checks++; if (err_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_err_cnt got=%h exp=0", err_cnt); end
    reset = 1'b1;
    repeat (10) tick();
    n_checks++; if (n_en !== 0) begin n_fail++; $display("FAIL init_enable got=%0d exp=0", n_en); end
    n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL init_err got=%0d exp=0", n_err); end
  endtask

  task automatic test_forward();
    clear_tally();
    set_ab(2'b01, 8); set_ab(2'b11, 8); set_ab(2'b10, 8); set_ab(2'b00, 8);
    n_checks++; if (n_en !== 4) begin n_fail++; $display("FAIL fwd_pulses got=%0d exp=4", n_en); end
    n_checks++; if (n_up !== 4) begin n_fail++; $display("FAIL fwd_up got=%0d exp=4", n_up); end
    n_checks++; if (n_lat_ok !== 4) begin n_fail++; $display("FAIL fwd_latency got=%0d exp=4", n_lat_ok); end
    n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL fwd_err got=%0d exp=0", n_err); end
  endtask

  task automatic test_glitch();
    clear_tally();
    {a_in, b_in} = 2'b10;
    @(negedge clk); @(negedge clk);
    set_ab(2'b00, 12);
    n_checks++; if (n_en !== 0) begin n_fail++; $display("FAIL glitch_enable got=%0d exp=0", n_en); end
    n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL glitch_err got=%0d exp=0", n_err); end
    clear_tally();
    set_ab(2'b01, 8); set_ab(2'b00, 8);
    n_checks++; if (n_en !== 2 || dirs[1:0] !== 2'b10) begin
      n_fail++; $display("FAIL glitch_state got=%0d/%b exp=2/10", n_en, dirs[1:0]);
    end
  endtask

  task automatic test_reverse();
    clear_tally();
    set_ab(2'b10, 8); set_ab(2'b11, 8); set_ab(2'b01, 8); set_ab(2'b11, 8);
    n_checks++; if (n_en !== 4) begin n_fail++; $display("FAIL rev_pulses got=%0d exp=4", n_en); end
    n_checks++; if (dirs[3:0] !== 4'b0001) begin n_fail++; $display("FAIL rev_dirs got=%b exp=0001", dirs[3:0]); end
    n_checks++; if (n_lat_ok !== 4) begin n_fail++; $display("FAIL rev_latency got=%0d exp=4", n_lat_ok); end
    n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL rev_err got=%0d exp=0", n_err); end
  endtask

  task automatic test_illegal();
    clear_tally();
    for (int i = 0; i < 17; i++) begin
      set_ab((i % 2 == 0) ? 2'b00 : 2'b11, 8);
      if (i == 4) begin
        n_checks++;
        if (err_cnt !== (CNT_EN ? 4'd5 : 4'd0)) begin
          n_fail++; $display("FAIL errcnt_mid got=%h exp=%h", err_cnt, CNT_EN ? 4'd5 : 4'd0);
        end
      end
    end
    n_checks++; if (n_err !== 17) begin n_fail++; $display("FAIL ill_err got=%0d exp=17", n_err); end
    n_checks++; if (n_en !== 0) begin n_fail++; $display("FAIL ill_enable got=%0d exp=0", n_en); end
    n_checks++; if (err_cnt !== (CNT_EN ? 4'hF : 4'h0)) begin
      n_fail++; $display("FAIL errcnt_sat got=%h exp=%h", err_cnt, CNT_EN ? 4'hF : 4'h0);
    end
    n_checks++; if (up_down !== 1'b1) begin n_fail++; $display("FAIL ill_up_down got=%b exp=1", up_down); end
    n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL ill_overlap got=%0d exp=0", n_both); end
  endtask

  task automatic test_dec_en();
    clear_tally();
    dec_en = 1'b0;
    set_ab(2'b01, 8); set_ab(2'b11, 8);
    n_checks++; if (n_en !== 0 || up_down !== 1'b1) begin
      n_fail++; $display("FAIL dis_quiet got=%0d/%b exp=0/1", n_en, up_down);
    end
    dec_en = 1'b1;
    clear_tally();
    set_ab(2'b01, 8);
    n_checks++; if (n_en !== 1 || n_dn !== 1) begin
      n_fail++; $display("FAIL en_step got=%0d/%0d exp=1/1", n_en, n_dn);
    end
    n_checks++; if (up_down !== 1'b0) begin n_fail++; $display("FAIL en_dir got=%b exp=0", up_down); end
  endtask

  task automatic test_reset_mid();
    clear_tally();
    {a_in, b_in} = 2'b11;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (up_down !== 1'b1 || enable !== 1'b0 || err_cnt !== 4'h0) begin
      n_fail++; $display("FAIL async_reset got=%b%b%h exp=1 0 0", up_down, enable, err_cnt);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) tick();
    n_checks++; if (n_en !== 0 || n_err !== 0) begin
      n_fail++; $display("FAIL midreset_step got=%0d/%0d exp=0/0", n_en, n_err);
    end
  endtask

  task automatic test_random();
    logic [6:0] got_v, exp_v;
    int hold;
    for (int seg = 0; seg < 70; seg++) begin
      {a_in, b_in} = 2'($urandom_range(0, 3));
      dec_en = ($urandom_range(0, 5) != 0);
      hold = $urandom_range(1, 8);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        got_v = {enable, err, up_down, err_cnt};
        exp_v = {exp_en, exp_err, exp_ud, exp_cnt};
        n_checks++;
        if (got_v !== exp_v) begin
          n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_glitch();
    test_reverse();
    test_illegal();
    test_dec_en();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
